// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU and its two-client arbiter.
//   DEF_W          default datapath width
//   OP_*           ALU opcodes; 9..14 are reserved and treated as illegal
//   state_e        arbiter sequencing states
//   is_illegal()   true for the reserved opcode range
package alu_pkg;

  localparam int DEF_W = 16;

  localparam logic [3:0] OP_NOOP  = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_MULT  = 4'd3;
  localparam logic [3:0] OP_DIV   = 4'd4;
  localparam logic [3:0] OP_AND   = 4'd5;
  localparam logic [3:0] OP_OR    = 4'd6;
  localparam logic [3:0] OP_XOR   = 4'd7;
  localparam logic [3:0] OP_NOT   = 4'd8;
  localparam logic [3:0] OP_RESET = 4'd15;

  localparam logic [3:0] OP_ILL_LO = 4'd9;
  localparam logic [3:0] OP_ILL_HI = 4'd14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= OP_ILL_LO) && (op <= OP_ILL_HI);
  endfunction

endpackage

// File: rtl/alu.sv
// alu: 16-bit ALU with an internal accumulator (the shared ALU instance).
//   clk, rst_n      clock and asynchronous active-low reset (clears accumulator)
//   in1, in2        operands
//   opcode          operation; NOOP and reserved codes keep the accumulator
//   alu_out         combinational result, also the accumulator D input
// The accumulator captures alu_out on every clock, so a NOOP holds its value
// and presents it on alu_out.
module alu
  import alu_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [3:0]   opcode,
  output logic [W-1:0] alu_out
);

  logic [W-1:0] acc_q;
  logic [W-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    case (opcode)
      OP_ADD:   acc_d = in1 + in2;
      OP_SUB:   acc_d = in1 - in2;
      OP_MULT:  acc_d = in1 * in2;   // W-bit context keeps the low W bits
      OP_DIV:   acc_d = (in2 == '0) ? '1 : in1 / in2;
      OP_AND:   acc_d = in1 & in2;
      OP_OR:    acc_d = in1 | in2;
      OP_XOR:   acc_d = in1 ^ in2;
      OP_NOT:   acc_d = ~in1;
      OP_RESET: acc_d = '0;
      default:  acc_d = acc_q;
    endcase
  end

  assign alu_out = acc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      // NOTE: non-blocking assignment so every flop samples pre-edge values,
      // independent of the order in which always_ff blocks are evaluated.
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin grant.
//   valid[1:0]  in   request lines
//   prio        in   requester that wins when both are valid
//   grant[1:0]  out  one-hot grant (all zero when nothing is valid)
// The priority pointer itself lives in the instantiating block.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       prio,
  output logic [1:0] grant
);

  always_comb begin
    // NOTE: assigning a default before any condition keeps this purely
    // combinational; a path that leaves grant unassigned would infer a latch.
    grant = valid;
    if (valid == 2'b11) begin
      grant = prio ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two clients.
//   clk, rst_n                       clock, asynchronous active-low reset
//   reqN_valid/ready                 request handshake per client (N = 0, 1)
//   reqN_op, reqN_a, reqN_b          request payload
//   rsp_valid/ready                  response handshake
//   rsp_id, rsp_data, rsp_err        owner, result and error flag
//   alu_in1, alu_in2, alu_opcode     ALU drive (NOOP / 0 except in ISSUE)
//   alu_out                          ALU combinational result
// Sequence: IDLE (arbitrate, accept) -> ISSUE (one ALU cycle) -> RESP
// (hold until consumed). Rejected operations never reach the ALU, so the
// shared accumulator is left untouched by them.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [3:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [3:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_data,
  output logic         rsp_err,
  output logic [W-1:0] alu_in1,
  output logic [W-1:0] alu_in2,
  output logic [3:0]   alu_opcode,
  input  logic [W-1:0] alu_out
);

  state_e       state_q, state_d;
  logic         prio_q, prio_d;
  logic [3:0]   op_q, op_d;
  logic [W-1:0] b_q, b_d;
  logic         id_q, id_d;
  logic [3:0]   alu_op_q, alu_op_d;
  logic [W-1:0] alu_in1_q, alu_in1_d;
  logic [W-1:0] alu_in2_q, alu_in2_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_id_q, rsp_id_d;
  logic [W-1:0] rsp_data_q, rsp_data_d;
  logic         rsp_err_q, rsp_err_d;

  logic [1:0]   grant;
  logic         idle;
  logic         win_id;
  logic [3:0]   win_op;
  logic [W-1:0] win_a, win_b;
  logic         win_reject;
  logic         div0_q;

  rr_arb2 u_arb (
    .valid ({req1_valid, req0_valid}),
    .prio  (prio_q),
    .grant (grant)
  );

  assign idle    = (state_q == IDLE);
  assign win_id  = grant[1];
  assign win_op  = win_id ? req1_op : req0_op;
  assign win_a   = win_id ? req1_a  : req0_a;
  assign win_b   = win_id ? req1_b  : req0_b;
  // Rejected requests are steered to NOOP before they are issued.
  assign win_reject = ((win_op == OP_DIV) && (win_b == '0)) || is_illegal(win_op);
  assign div0_q     = (op_q == OP_DIV) && (b_q == '0);

  // Ready is gated by rst_n so it reads low for the whole reset window,
  // even while a client holds valid high.
  assign req0_ready = rst_n && idle && grant[0];
  assign req1_ready = rst_n && idle && grant[1];

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    op_d        = op_q;
    b_d         = b_q;
    id_d        = id_q;
    alu_op_d    = alu_op_q;
    alu_in1_d   = alu_in1_q;
    alu_in2_d   = alu_in2_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          op_d    = win_op;
          b_d     = win_b;
          id_d    = win_id;
          prio_d  = ~win_id;
          state_d = ISSUE;
          if (win_reject) begin
            alu_op_d  = OP_NOOP;
            alu_in1_d = '0;
            alu_in2_d = '0;
          end else begin
            alu_op_d  = win_op;
            alu_in1_d = win_a;
            alu_in2_d = win_b;
          end
        end
      end

      ISSUE: begin
        alu_op_d    = OP_NOOP;
        alu_in1_d   = '0;
        alu_in2_d   = '0;
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        if (div0_q) begin
          rsp_data_d = '1;
          rsp_err_d  = 1'b1;
        end else if (is_illegal(op_q)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
        end else begin
          rsp_data_d = alu_out;
          rsp_err_d  = 1'b0;
        end
        state_d = RESP;
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      op_q        <= OP_NOOP;
      b_q         <= '0;
      id_q        <= 1'b0;
      alu_op_q    <= OP_NOOP;
      alu_in1_q   <= '0;
      alu_in2_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      op_q        <= op_d;
      b_q         <= b_d;
      id_q        <= id_d;
      alu_op_q    <= alu_op_d;
      alu_in1_q   <= alu_in1_d;
      alu_in2_q   <= alu_in2_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign alu_opcode = alu_op_q;
  assign alu_in1    = alu_in1_q;
  assign alu_in2    = alu_in2_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: alu_arbiter + alu with directed scenarios followed by
// randomized traffic. A reference model (plain integer arithmetic, an
// accumulator variable and a round-robin pointer) predicts each grant and
// pushes the expected response into a scoreboard queue; a negedge monitor
// checks handshakes, ALU drive, latency, hold stability and pops responses.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int W = DEF_W;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic [1:0]   v;
  logic [3:0]   op [2];
  logic [W-1:0] a  [2];
  logic [W-1:0] b  [2];
  logic         rr;

  logic         req0_ready, req1_ready;
  logic         rsp_valid, rsp_id, rsp_err;
  logic [W-1:0] rsp_data;
  logic [W-1:0] alu_in1, alu_in2, alu_out;
  logic [3:0]   alu_opcode;

  always #5 clk = ~clk;

  alu_arbiter #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (v[0]),
    .req0_ready (req0_ready),
    .req0_op    (op[0]),
    .req0_a     (a[0]),
    .req0_b     (b[0]),
    .req1_valid (v[1]),
    .req1_ready (req1_ready),
    .req1_op    (op[1]),
    .req1_a     (a[1]),
    .req1_b     (b[1]),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rr),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out)
  );

  alu #(.W(W)) u_alu (
    .clk     (clk),
    .rst_n   (rst_n),
    .in1     (alu_in1),
    .in2     (alu_in2),
    .opcode  (alu_opcode),
    .alu_out (alu_out)
  );

  // ---------------------------------------------------------------- scoreboard
  typedef struct {
    int id;
    int data;
    int err;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // Reference model state
  int          m_acc    = 0;
  int          m_prio   = 0;
  bit          m_idle   = 1'b1;
  int          m_cnt    = 0;
  int          m_grants = 0;
  int          e_op, e_a, e_b, e_err;
  bit          hs [2];
  bit          chk_en = 1'b0;
  logic [17:0] p_hold;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no completion within cycle budget (t=%0t)", name, $time);
  endtask

  // Operation semantics from the opcode table; updates the model accumulator
  // and records what the ALU should be driven with in the issue cycle.
  task automatic model_exec(input int o, input int x, input int y,
                            output int data, output int err);
    data = 0;
    err  = 0;
    case (o)
      0:  data = m_acc;
      1:  data = (x + y) % 65536;
      2:  data = (x - y + 65536) % 65536;
      3:  data = int'((longint'(x) * longint'(y)) % 65536);
      4:  if (y == 0) begin data = 65535; err = 1; end
          else data = x / y;
      5:  data = x & y;
      6:  data = x | y;
      7:  data = x ^ y;
      8:  data = 65535 - x;
      15: data = 0;
      default: begin data = 0; err = 1; end
    endcase
    e_err = err;
    if (err != 0) begin
      e_op = 0; e_a = 0; e_b = 0;
    end else begin
      e_op = o; e_a = x; e_b = y;
      m_acc = data;
    end
  endtask

  // ------------------------------------------------------------------ monitor
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      if (m_idle) begin
        check("idle_alu_op", alu_opcode, 0);
        check("idle_rsp_valid", rsp_valid, 0);
        if (v != 2'b00) begin
          int   w;
          int   d, er;
          exp_t e;
          w = (v == 2'b11) ? m_prio : (v[1] ? 1 : 0);
          check("grant", {req1_ready, req0_ready}, (w == 1) ? 2 : 1);
          model_exec(op[w], a[w], b[w], d, er);
          e.id = w; e.data = d; e.err = er;
          sb.push_back(e);
          hs[w]    = 1'b1;
          m_prio   = 1 - w;
          m_idle   = 1'b0;
          m_cnt    = 0;
          m_grants++;
        end else begin
          check("no_grant", {req1_ready, req0_ready}, 0);
        end
      end else begin
        m_cnt++;
        check("busy_ready", {req1_ready, req0_ready}, 0);
        if (m_cnt == 1) begin
          check("issue_alu_op", alu_opcode, e_op);
          if (e_err == 0) check("issue_alu_in", {alu_in1, alu_in2}, {e_a[15:0], e_b[15:0]});
          check("issue_rsp_valid", rsp_valid, 0);
        end else begin
          check("resp_alu_drive", {alu_opcode, alu_in1, alu_in2}, 0);
          check("rsp_valid", rsp_valid, 1);
          if (m_cnt > 2) check("rsp_hold", {rsp_id, rsp_err, rsp_data}, p_hold);
          p_hold = {rsp_id, rsp_err, rsp_data};
          if (rsp_valid && rr) begin
            if (sb.size() == 0) begin
              timeout("rsp_unexpected");
            end else begin
              exp_t e;
              e = sb.pop_front();
              check("rsp_id", rsp_id, e.id);
              check("rsp_data", rsp_data, e.data);
              check("rsp_err", rsp_err, e.err);
            end
            m_idle = 1'b1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic wait_hs(input int r);
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      if (hs[r]) begin
        hs[r] = 1'b0;
        return;
      end
    end
    timeout("handshake");
  endtask

  // Called just after a posedge; returns just after the handshake edge.
  task automatic send(input int r, input logic [3:0] o, input logic [W-1:0] x,
                      input logic [W-1:0] y);
    hs[r] = 1'b0;
    v[r]  = 1'b1;
    op[r] = o;
    a[r]  = x;
    b[r]  = y;
    wait_hs(r);
    #1 v[r] = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(posedge clk);
      if (m_idle && sb.size() == 0) done = 1'b1;
    end
    if (!done) timeout("drain");
    #1;
  endtask

  task automatic new_req(input int r);
    v[r]  = 1'b1;
    op[r] = 4'($urandom_range(0, 15));
    a[r]  = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
    b[r]  = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 300));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g0;
    bit hit;
    v = 2'b00;
    for (int r = 0; r < 2; r++) begin
      op[r] = '0; a[r] = '0; b[r] = '0; hs[r] = 1'b0;
    end
    rr = 1'b1;

    // Reset values while reset is held
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("reset_ready", {req1_ready, req0_ready}, 0);
    check("reset_rsp", {rsp_valid, rsp_id, rsp_err, rsp_data}, 0);
    check("reset_alu", {alu_opcode, alu_in1, alu_in2}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // Single request, then a req1 grant so the pointer returns to 0
    send(0, OP_ADD, 16'd1, 16'd1);
    wait_idle();
    send(1, OP_NOOP, 16'd0, 16'd0);
    wait_idle();

    // Contention held over three grants: id0, id1, id0
    hs[0] = 1'b0; hs[1] = 1'b0;
    op[0] = OP_SUB;  a[0] = 16'd3; b[0] = 16'd1;
    op[1] = OP_MULT; a[1] = 16'd2; b[1] = 16'd2;
    v = 2'b11;
    g0 = m_grants;
    hit = 1'b0;
    for (int i = 0; i < 64 && !hit; i++) begin
      @(posedge clk);
      if (m_grants >= g0 + 3) hit = 1'b1;
    end
    if (!hit) timeout("contention");
    #1 v = 2'b00;
    hs[0] = 1'b0; hs[1] = 1'b0;
    wait_idle();

    // Divide by zero leaves the accumulator alone
    send(1, OP_DIV, 16'd8, 16'd0);
    send(1, OP_NOOP, 16'd0, 16'd0);
    wait_idle();

    // Back-pressure with req1 pending
    rr = 1'b0;
    send(0, OP_XOR, 16'h00ff, 16'h0f0f);
    hs[1] = 1'b0;
    v[1] = 1'b1; op[1] = OP_ADD; a[1] = 16'd7; b[1] = 16'd9;
    repeat (7) @(posedge clk);
    #1 rr = 1'b1;
    wait_hs(1);
    #1 v[1] = 1'b0;
    wait_idle();

    // Illegal opcode, RESET, then NOOP reads zero
    send(0, 4'b1010, 16'd5, 16'd6);
    send(0, OP_RESET, 16'd1, 16'd2);
    send(0, OP_NOOP, 16'd0, 16'd0);
    wait_idle();

    // Asynchronous reset while in ISSUE
    send(0, OP_ADD, 16'd5, 16'd6);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ready", {req1_ready, req0_ready}, 0);
    check("async_rst_rsp", {rsp_valid, rsp_id, rsp_err, rsp_data}, 0);
    check("async_rst_alu", {alu_opcode, alu_in1, alu_in2}, 0);
    sb.delete();
    m_idle = 1'b1; m_prio = 0; m_acc = 0; m_cnt = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // Pointer back at 0: both valid, requester 0 must win
    hs[0] = 1'b0; hs[1] = 1'b0;
    op[0] = OP_OR;  a[0] = 16'h1200; b[0] = 16'h0034;
    op[1] = OP_NOT; a[1] = 16'h00f0; b[1] = 16'h0000;
    v = 2'b11;
    wait_hs(0);
    #1 v[0] = 1'b0;
    wait_hs(1);
    #1 v[1] = 1'b0;
    wait_idle();

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      @(posedge clk);
      #1;
      for (int r = 0; r < 2; r++) begin
        if (hs[r]) begin
          hs[r] = 1'b0;
          v[r]  = 1'b0;
          if ($urandom_range(0, 1) == 1) new_req(r);
        end else if (!v[r]) begin
          if ($urandom_range(0, 2) == 0) new_req(r);
        end else if ($urandom_range(0, 19) == 0) begin
          v[r] = 1'b0;
        end
      end
      rr = ($urandom_range(0, 3) != 0);
    end
    v  = 2'b00;
    rr = 1'b1;
    wait_idle();
    hs[0] = 1'b0; hs[1] = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter and sequencer that shares the single 16-bit ALU (with its internal accumulator) between two clients. Each client presents an operation and its operands with a valid/ready handshake. The arbiter registers the winning request, drives the ALU for exactly one clock so the accumulator captures the result, then returns the result tagged with the requester id. It sits between the client logic and the ALU instance, and is the only block allowed to drive the ALU's input1, input2 and opcode.

## Interface
- W, 16, datapath width; must match the ALU width.
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_op / req1_op  in  4  ALU opcode: NOOP=0, ADD=1, SUB=2, MULT=3, DIV=4, AND=5, OR=6, XOR=7, NOT=8, RESET=15.
- req0_a, req0_b / req1_a, req1_b  in  W  operands.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  index of the requester that owns the response.
- rsp_data  out  W  result.
- rsp_err  out  1  operation rejected or illegal.
- alu_in1, alu_in2  out  W  ALU operand drive.
- alu_opcode  out  4  ALU opcode drive.
- alu_out  in  W  ALU combinational output (accumulator D input).

## Operation
- State machine states: IDLE, ISSUE, RESP.
- **IDLE**
  - Arbitration is combinational on the valids.
  - If exactly one valid is high, that requester wins.
  - If both are high, the requester indicated by the priority pointer `prio` wins.
  - The winner's ready is asserted; the other ready stays low. Ready is never high outside IDLE.
  - On handshake, latch op, a, b and id, then go to ISSUE.
  - After each grant, `prio` moves to the non-winning requester. The pointer is updated only on a grant.
- **ISSUE** (exactly one cycle)
  - Drive the latched a, b and op onto the ALU.
  - Capture alu_out into rsp_data, then go to RESP.
- **Error cases** (decided in ISSUE):
  - DIV with b==0: drive alu_opcode=NOOP (accumulator unchanged), rsp_data=all ones, rsp_err=1.
  - Opcode 9–14: drive NOOP, rsp_data=0, rsp_err=1.
- **RESP**
  - rsp_valid=1, holding rsp_id, rsp_data and rsp_err stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE.
- **Outside ISSUE**, drive alu_opcode=NOOP, alu_in1=0, alu_in2=0, so the accumulator holds its value.
- **Widths:** MULT returns the low W bits of the product; ADD and SUB wrap modulo 2^W.
- **Shared accumulator:** a NOOP request returns the current accumulator, whichever client last wrote it.

## Timing
- **Reset values:**
  - State IDLE, prio=0.
  - All ready outputs 0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0.
  - alu_opcode=NOOP, alu_in1=0, alu_in2=0.
- **Latency:** handshake in cycle N, ALU driven in cycle N+1, rsp_valid high from cycle N+2.
- **Throughput:** one operation per 3 cycles at best (rsp_ready held high).
- **Back-pressure:** rsp_ready low keeps the block in RESP. Both readies stay low, and the ALU sees NOOP.
- **Simultaneous events:**
  - Both valids high with prio=0: requester 0 wins. The next contention is won by requester 1.
  - A requester holding valid high while losing keeps its payload stable and is guaranteed service after at most one other grant.
- **Reset mid-operation:** rst_n low in any state forces IDLE and the reset values immediately (asynchronous). Any in-flight request or pending response is dropped with no response issued.
- **Requester payload:** req*_valid may drop without a handshake; no request is latched in that case.

## Structure
- **Shared package `alu_pkg`:**
  - Opcode constants NOOP through RESET, plus the 9–14 illegal range.
  - State enum {IDLE, ISSUE, RESP}.
  - Default width W=16.
- **Sub-module `rr_arb2`:** combinational two-way round-robin grant.
  - Inputs: valid[1:0], prio.
  - Output: one-hot grant[1:0].
  - The pointer register stays in alu_arbiter.
- **Top level:** alu_arbiter instantiates rr_arb2. The bench instantiates alu_arbiter together with the existing ALU.

## Test plan
- **Single request:** after reset, req0 ADD a=1, b=1 with rsp_ready=1 → req0_ready in cycle 0, alu_opcode=ADD in cycle 1, rsp_valid in cycle 2 with id=0, data=2, err=0.
- **Contention:** both valid, req0 SUB 3,1 and req1 MULT 2,2, held continuously → responses in the order id0 data 2, then id1 data 4, then id0 again on the next contention.
- **Div by zero:** req1 DIV a=8, b=0 → rsp_err=1, data=16'hFFFF, alu_opcode stays NOOP. A following NOOP request returns the unchanged accumulator.
- **Back-pressure:** rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_id, rsp_data and rsp_err stable, both readies 0, ALU sees NOOP. Release → return to IDLE in the next cycle.
- **Illegal opcode and RESET:** req0 op=4'b1010 → err=1, data=0. Then req0 RESET → data 0, and a following NOOP returns 0.
- **Async reset:** assert rst_n low between clock edges while in ISSUE → all outputs at reset values immediately, no response afterwards, prio=0.
